// File: rtl/seq_det_pkg.sv
// seq_det_pkg: FSM state encodings and default sizes shared by the sequence-detect controller.
package seq_det_pkg;
   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_SHIFT = 2'b01,
      ST_DONE  = 2'b10
   } state_e;
   localparam int DEF_DATA_W = 16;
   localparam int DEF_PAT_W  = 5;
   localparam int DEF_CNT_W  = 5;
endpackage

// File: rtl/seq_det_match_core.sv
// seq_det_match_core: pattern history, fill counter, pattern compare and registered hit.
// SEQ_DET_CTRL_OVERLAP_EN keeps the fill count after a match so overlapping hits are counted.
module seq_det_match_core import seq_det_pkg::*; #(
   parameter int PAT_W = DEF_PAT_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             clr,
   input  logic             bit_in,
   input  logic [PAT_W-1:0] pattern,
   output logic             match,
   output logic             hit
);
   localparam int FW = $clog2(PAT_W + 1);
   localparam logic [FW-1:0] FULL = FW'(PAT_W);
   logic [PAT_W-1:0] hist_q, hist_d, hist_nx, pat_q, pat_d;
   logic [FW-1:0]    fill_q, fill_d, fill_inc;
   logic             hit_q;
   always_comb begin
      hist_nx  = {hist_q[PAT_W-2:0], bit_in};
      hist_d   = clr ? '0 : en ? hist_nx : hist_q;
      pat_d    = clr ? pattern : pat_q;
      fill_inc = (fill_q == FULL) ? fill_q : fill_q + 1'b1;
      match    = en && (hist_nx == pat_q) && (fill_inc == FULL);
`ifdef SEQ_DET_CTRL_OVERLAP_EN
      fill_d   = clr ? '0 : en ? fill_inc : fill_q;
`else
      fill_d   = clr ? '0 : !en ? fill_q : match ? '0 : fill_inc;
`endif
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hist_q <= '0;
         pat_q  <= '0;
         fill_q <= '0;
         hit_q  <= 1'b0;
      end else begin
         hist_q <= hist_d;
         pat_q  <= pat_d;
         fill_q <= fill_d;
         hit_q  <= match;
      end
   end
   assign hit = hit_q;
endmodule

// File: rtl/seq_det_ctrl.sv
// seq_det_ctrl: loads a word on start and streams it MSB-first into the match core, counting hits.
// Overlapping-match counting is enabled by defining SEQ_DET_CTRL_OVERLAP_EN.
module seq_det_ctrl import seq_det_pkg::*; #(
   parameter int DATA_W = DEF_DATA_W,
   parameter int PAT_W  = DEF_PAT_W,
   parameter int CNT_W  = DEF_CNT_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [DATA_W-1:0] data_in,
   input  logic [PAT_W-1:0]  pattern,
   output logic              bit_out,
   output logic              hit,
   output logic [CNT_W-1:0]  hit_count,
   output logic              busy,
   output logic              done,
   output logic [1:0]        state
);
   localparam int BW = $clog2(DATA_W);
   localparam logic [BW-1:0] LAST = BW'(DATA_W - 1);
   state_e            state_q, state_d;
   logic [DATA_W-1:0] shreg_q, shreg_d;
   logic [BW-1:0]     bitcnt_q, bitcnt_d;
   logic [CNT_W-1:0]  hit_count_q, hit_count_d;
   logic              start_ok, shifting, match;
   assign start_ok = (state_q == ST_IDLE) && start;
   assign shifting = (state_q == ST_SHIFT);
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end
   // DONE and the illegal code both fall back to IDLE
   always_comb begin
      state_d = start_ok ? ST_SHIFT :
                shifting ? ((bitcnt_q == LAST) ? ST_DONE : ST_SHIFT) : ST_IDLE;
   end
   always_comb begin
      busy    = shifting;
      done    = (state_q == ST_DONE);
      bit_out = shifting & shreg_q[DATA_W-1];
      state   = state_q;
   end
   always_comb begin
      shreg_d     = start_ok ? data_in : shifting ? {shreg_q[DATA_W-2:0], 1'b0} : shreg_q;
      bitcnt_d    = start_ok ? '0 : shifting ? bitcnt_q + 1'b1 : bitcnt_q;
      hit_count_d = start_ok ? '0 : (match && hit_count_q != '1) ? hit_count_q + 1'b1 : hit_count_q;
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         shreg_q     <= '0;
         bitcnt_q    <= '0;
         hit_count_q <= '0;
      end else begin
         shreg_q     <= shreg_d;
         bitcnt_q    <= bitcnt_d;
         hit_count_q <= hit_count_d;
      end
   end
   assign hit_count = hit_count_q;
   seq_det_match_core #(.PAT_W(PAT_W)) u_core (
      .clk     (clk),
      .reset   (reset),
      .en      (shifting),
      .clr     (start_ok),
      .bit_in  (bit_out),
      .pattern (pattern),
      .match   (match),
      .hit     (hit)
   );
endmodule
